ahb_slave_mem: RTL

// - AHB-Lite responder backing the CRC engine's AHB master: a word-addressed RAM the master reads

---
 rtl/ahb_pkg.sv | 39 +++
 rtl/ahb_slave_ram.sv | 28 ++
 rtl/ahb_slave_mem.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state encoding for the slave memory.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_HALF = 3'b001;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_DATA = ST_DATA,
        S_ERR1 = ST_ERR1,
        S_ERR2 = ST_ERR2
    } state_e;

    // NONSEQ and SEQ carry a real beat; IDLE and BUSY never do.
    function automatic logic trans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Word-addressed single-port storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module ahb_slave_ram
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 256,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Commit a write word at the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-addressed RAM.
// Optional feature macro: RESP_ERR_EN -- out-of-range addresses and non-halfword
// sizes get a two-cycle ERROR response. Without it, addresses wrap onto the
// RAM and HSIZE is ignored; HRESP is always OKAY.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  RESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic                  HRESP
);

    localparam int         RAM_AW    = $clog2(MEM_DEPTH);
    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    // Counter is preloaded with one less than the stretch length and exits at zero.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    state_e              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [RAM_AW-1:0]   addr_q, addr_d;
    logic                write_q, write_d;

    logic                hready_s;
    logic                hresp_s;
    logic                rd_en_s;
    logic                accept_s;
    logic                legal_s;
    logic                size_ok_s;
    logic                we_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;
    logic                unused_s;

    assign size_ok_s = (HSIZE == HSIZE_HALF);

`ifdef RESP_ERR_EN
    assign legal_s = (32'(HADDR) < 32'(MEM_DEPTH)) && size_ok_s;
`else
    assign legal_s = 1'b1;
`endif

    // Sideband and upper address bits that carry no meaning for this slave.
    assign unused_s = ^{HBURST, HMASTLOCK, HADDR, size_ok_s};

    assign accept_s = HSEL && hready_s && trans_active(HTRANS);

    // Next-state, wait counter and address/control phase capture.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        case (state_q)
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept_s) begin
                    addr_d  = HADDR[RAM_AW-1:0];
                    write_d = HWRITE;
                    if (!legal_s) begin
                        state_d = S_ERR1;
                    end else if (HAS_WAIT) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus response decoded purely from the registered state.
    always_comb begin
        hready_s = 1'b1;
        hresp_s  = HRESP_OKAY;
        rd_en_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                hready_s = 1'b1;
            end
            S_WAIT: begin
                hready_s = 1'b0;
            end
            S_DATA: begin
                rd_en_s = !write_q;
            end
            S_ERR1: begin
                hready_s = 1'b0;
                hresp_s  = HRESP_ERROR;
            end
            S_ERR2: begin
                hresp_s = HRESP_ERROR;
            end
            default: begin
                hready_s = 1'b1;
            end
        endcase
    end

    // State and phase registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= {RAM_AW{1'b0}};
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
        end
    end

    // The write lands at the edge closing the DATA cycle; reset at that edge cancels it.
    assign we_s = (state_q == S_DATA) && write_q && RESET;

    ahb_slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk   (HCLK),
        .we    (we_s),
        .addr  (addr_q),
        .wdata (HWDATA),
        .rdata (ram_rdata_s)
    );

    assign HREADY = hready_s;
`ifdef RESP_ERR_EN
    assign HRESP  = hresp_s;
`else
    assign HRESP  = HRESP_OKAY;
`endif
    assign HRDATA = rd_en_s ? ram_rdata_s : {DATA_WIDTH{1'b0}};

endmodule
